// File: rtl/core_pkg.sv
// Shared core definitions: NOP encoding, RISC-V major opcodes and the fetch entry type.
package core_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] LOAD    = 7'b0000011;
  localparam logic [6:0] STORE   = 7'b0100011;
  localparam logic [6:0] BRANCH  = 7'b1100011;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] AUIPC   = 7'b0010111;
  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] FENCES  = 7'b0001111;
  localparam logic [6:0] SYSCALL = 7'b1110011;

  typedef struct packed {
    logic [19:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fifo_storage_ram.sv
// Entry storage for the fetch queue: one synchronous write port, one async read port.
module fifo_storage_ram #(
  parameter  int WIDTH = 52,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction buffer with redirect flush and cycle report.
// INST_FETCH_QUEUE_BYPASS_EN: empty-queue input passes straight to the head outputs.
module inst_fetch_queue
  import core_pkg::*;
#(
  parameter  int CORE             = 0,
  parameter  int DATA_WIDTH       = 32,
  parameter  int ADDRESS_BITS     = 20,
  parameter  int DEPTH            = 4,
  parameter  int PRINT_CYCLES_MIN = 1,
  parameter  int PRINT_CYCLES_MAX = 1000,
  localparam int AW               = $clog2(DEPTH),
  localparam int CW               = AW + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0]   in_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]   out_inst,
  output logic [6:0]              out_opcode,
  input  logic                    flush,
  output logic [CW-1:0]           count,
  input  logic                    report
);
  localparam int EW = ADDRESS_BITS + DATA_WIDTH;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   cycles;
  logic [EW-1:0] rd_data;
  logic          empty, bypass, enq, deq, wr_en, pop;

  assign empty    = (count == '0);
  assign in_ready = (count != CW'(DEPTH));

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !flush && reset;
`else
  assign bypass = 1'b0;
`endif

  assign enq   = in_valid && in_ready;
  assign deq   = out_valid && out_ready;
  // A bypassed entry consumed the same cycle never touches storage.
  assign wr_en = enq && !(bypass && out_ready) && !flush && reset;
  assign pop   = deq && !bypass;

  fifo_storage_ram #(.WIDTH(EW), .DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_inst}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_comb begin
    out_valid = !empty;
    out_pc    = rd_data[EW-1:DATA_WIDTH];
    out_inst  = rd_data[DATA_WIDTH-1:0];
    if (empty) begin
      out_pc   = '0;
      out_inst = DATA_WIDTH'(NOP_INST);
    end
    if (bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end
  end

  assign out_opcode = out_inst[6:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(wr_en) - CW'(pop);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset && report && cycles >= PRINT_CYCLES_MIN && cycles <= PRINT_CYCLES_MAX)
      $display("[core %0d] cycle %0d count %0d pc %h inst %h iv %b ir %b ov %b or %b flush %b",
               CORE, cycles, count, out_pc, out_inst, in_valid, in_ready, out_valid,
               out_ready, flush);
  end
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;
  import core_pkg::*;
  localparam int DEPTH = 4, AB = 20, DW = 32, CW = 3;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, in_valid, in_ready, out_valid, out_ready, flush, report;
  logic [AB-1:0] in_pc, out_pc;
  logic [DW-1:0] in_inst, out_inst;
  logic [6:0]    out_opcode;
  logic [CW-1:0] count;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_opcode(out_opcode), .flush(flush),
    .count(count), .report(report)
  );

  typedef struct { logic [AB-1:0] pc; logic [DW-1:0] inst; } ent_t;
  ent_t q[$];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs from current model contents and the inputs being driven.
  task automatic compare();
    logic          e_ov;
    logic [AB-1:0] e_pc;
    logic [DW-1:0] e_inst;
    e_ov = 1'b0; e_pc = '0; e_inst = NOP_INST;
    if (q.size() > 0) begin
      e_ov = 1'b1; e_pc = q[0].pc; e_inst = q[0].inst;
    end else if (BYP && in_valid && !flush && reset) begin
      e_ov = 1'b1; e_pc = in_pc; e_inst = in_inst;
    end
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("out_pc", 64'(out_pc), 64'(e_pc));
    chk("out_inst", 64'(out_inst), 64'(e_inst));
    chk("out_opcode", 64'(out_opcode), 64'(e_inst[6:0]));
  endtask

  task automatic cyc(input logic r, input logic iv, input logic [AB-1:0] pc,
                     input logic [DW-1:0] inst, input logic ordy, input logic fl);
    bit was_empty, can_enq, ov, dq;
    ent_t e;
    reset = r; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    #1;
    compare();
    if (!r || fl) q.delete();
    else begin
      e.pc = pc; e.inst = inst;
      was_empty = (q.size() == 0);
      can_enq   = iv && (q.size() != DEPTH);
      ov        = !was_empty || (BYP && iv);
      dq        = ov && ordy;
      if (was_empty && BYP && iv) begin
        if (!dq) q.push_back(e);
      end else begin
        if (dq) void'(q.pop_front());
        if (can_enq) q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b0; flush = 1'b0; report = 1'b0;
    @(posedge clock); #1;

    // Reset held with in_valid asserted
    cyc(0, 1, 20'h40, 32'h0000006F, 0, 0);
    cyc(0, 1, 20'h44, 32'h0000006F, 0, 0);
    reset = 1'b1; in_valid = 1'b0; #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_inst", 64'(out_inst), 64'h13);

    // Fill, overflow attempt, drain
    cyc(1, 1, 20'h0, 32'h00500093, 0, 0);
    cyc(1, 1, 20'h4, 32'h00A00113, 0, 0);
    cyc(1, 1, 20'h8, 32'h002081B3, 0, 0);
    cyc(1, 1, 20'hC, 32'h0000A203, 0, 0);
    cyc(1, 1, 20'h10, 32'h00000033, 0, 0);
    in_valid = 1'b0; #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("head_opcode", 64'(out_opcode), 64'h13);
    chk("head_pc", 64'(out_pc), 64'h0);
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, '0, 1, 0);
    chk("drained_count", 64'(count), 64'd0);

    // Wrap-around at occupancy 2
    cyc(1, 1, 20'h20, 32'h00000013, 0, 0);
    cyc(1, 1, 20'h24, 32'h00000013, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, AB'(20'h28 + 4 * i), $urandom, 1, 0);
    chk("wrap_count", 64'(count), 64'd2);

    // Full with simultaneous dequeue: only the dequeue happens
    cyc(1, 1, 20'h60, 32'h00000013, 0, 0);
    cyc(1, 1, 20'h64, 32'h00000013, 0, 0);
    cyc(1, 1, 20'h68, 32'h00000013, 1, 0);
    chk("fulldeq_count", 64'(count), 64'd3);
    cyc(1, 1, 20'h68, 32'h00000013, 0, 0);
    chk("fulldeq_accept", 64'(count), 64'd4);

    // Flush mid-stream at count 3
    cyc(1, 0, '0, '0, 1, 0);
    cyc(1, 1, 20'h80, 32'h00000013, 0, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    cyc(1, 1, 20'h100, 32'h00000013, 0, 0);
    chk("post_flush_pc", 64'(out_pc), 64'h100);

    // Empty-queue JAL with out_ready high
    cyc(1, 0, '0, '0, 0, 1);
    in_valid = 1'b1; in_pc = 20'h200; in_inst = 32'h0000006F; out_ready = 1'b1; #1;
    chk("byp_out_valid", 64'(out_valid), 64'(BYP));
    if (BYP) chk("byp_opcode", 64'(out_opcode), 64'h6F);
    cyc(1, 1, 20'h200, 32'h0000006F, 1, 0);
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("byp_count", 64'(count), BYP ? 64'd0 : 64'd1);
    chk("byp_late_valid", 64'(out_valid), BYP ? 64'd0 : 64'd1);
    if (!BYP) chk("byp_late_opcode", 64'(out_opcode), 64'h6F);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      report = (i < 4);
      cyc(($urandom_range(0, 199) != 0), $urandom_range(0, 2) != 0, AB'($urandom),
          $urandom, $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1, $urandom_range(0, 24) == 0);
    end
    report = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
